// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory (1-cycle read
// latency) between an instruction-fetch port and a load/store port.
// Load/store has default priority; a fetch that has lost STARVE_LIMIT
// consecutive cycles is boosted above load/store for one grant.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_b,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  // load/store port
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [3:0]            ls_be,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  // memory port
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  // Owner of the read response returning in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             boost;

  // State register: response owner and fetch starvation counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Arbitration, memory mux and next-state; no dependence on mem_rdata.
  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    starve_d  = starve_q;
    boost     = if_req && (starve_q == STARVE_MAX);

    if (if_req && (!ls_req || boost)) begin
      if_gnt   = 1'b1;
      mem_en   = 1'b1;
      mem_be   = 4'hF;
      mem_addr = if_addr;
      owner_d  = OWN_IF;
    end else if (ls_req) begin
      ls_gnt    = 1'b1;
      mem_en    = 1'b1;
      mem_we    = ls_we;
      mem_be    = ls_be;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      owner_d   = ls_we ? OWN_NONE : OWN_LS;
    end

    if (!if_req || if_gnt) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Response steering: read data passes straight through to both ports.
  assign if_rvalid = (owner_q == OWN_IF);
  assign ls_rvalid = (owner_q == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
  assign busy      = (owner_q != OWN_NONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a response scoreboard for mem_arbiter.
module tb_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [3:0]    ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic          is_if;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_b(reset_b),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port memory with byte-enable writes.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle compare rvalids/busy/data against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    logic exp_if, exp_ls;
    exp_if = 1'b0;
    exp_ls = 1'b0;
    e.is_if = 1'b0;
    e.data  = '0;
    e.due   = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      exp_if = e.is_if;
      exp_ls = !e.is_if;
    end
    chk("if_rvalid", DW'(if_rvalid), DW'(exp_if));
    chk("ls_rvalid", DW'(ls_rvalid), DW'(exp_ls));
    chk("busy", DW'(busy), DW'(exp_if | exp_ls));
    if (exp_if) chk("if_rdata", if_rdata, e.data);
    if (exp_ls) chk("ls_rdata", ls_rdata, e.data);
  end

  // One request cycle: drive, check grant and memory strobe, queue expectation, advance.
  task automatic drive(input logic ir, input logic [AW-1:0] ia,
                       input logic lr, input logic we, input logic [3:0] be,
                       input logic [AW-1:0] la, input logic [DW-1:0] wd,
                       input logic eig, input logic elg);
    exp_t e;
    if_req = ir; if_addr = ia;
    ls_req = lr; ls_we = we; ls_be = be; ls_addr = la; ls_wdata = wd;
    #1;
    chk("if_gnt", DW'(if_gnt), DW'(eig));
    chk("ls_gnt", DW'(ls_gnt), DW'(elg));
    chk("mem_en", DW'(mem_en), DW'(eig | elg));
    if (eig) begin
      chk("mem_we_if", DW'(mem_we), DW'(1'b0));
      chk("mem_be_if", DW'(mem_be), DW'(4'hF));
      chk("mem_addr_if", DW'(mem_addr), DW'(ia));
      e.is_if = 1'b1; e.data = ref_mem[ia]; e.due = cyc + 1;
      q.push_back(e);
    end else if (elg) begin
      chk("mem_we_ls", DW'(mem_we), DW'(we));
      chk("mem_be_ls", DW'(mem_be), DW'(be));
      chk("mem_addr_ls", DW'(mem_addr), DW'(la));
      chk("mem_wdata_ls", mem_wdata, wd);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[la][8*b +: 8] = wd[8*b +: 8];
      end else begin
        e.is_if = 1'b0; e.data = ref_mem[la]; e.due = cyc + 1;
        q.push_back(e);
      end
    end else begin
      chk("idle_we", DW'(mem_we), DW'(1'b0));
      chk("idle_be", DW'(mem_be), DW'(4'h0));
      chk("idle_addr", DW'(mem_addr), DW'(0));
      chk("idle_wdata", mem_wdata, DW'(0));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = {16'hC0DE, 6'h0, AW'(i)} ^ 32'h1234_0000;
      ref_mem[i] = mem[i];
    end
    mem_rdata = '0;
    reset_b = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", DW'(busy), DW'(1'b0));
    reset_b = 1'b1;
    idle();

    // Fetch alone is granted at once, response next cycle.
    drive(1'b1, 10'h004, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    idle();

    // Contention: load/store wins, then the held fetch goes through.
    drive(1'b1, 10'h008, 1'b1, 1'b0, 4'hF, 10'h010, '0, 1'b0, 1'b1);
    drive(1'b1, 10'h008, 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
    idle();

    // Partial store produces no response; read it back to see the byte lanes.
    drive(1'b0, '0, 1'b1, 1'b1, 4'b0011, 10'h020, 32'hDEADBEEF, 1'b0, 1'b1);
    idle();
    drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 10'h020, '0, 1'b0, 1'b1);
    idle();

    // Starvation: fetch boosted on cycles 4 and 9 of a 10-cycle contention run.
    for (int k = 0; k < 10; k++) begin
      logic fw;
      fw = (k == 4) || (k == 9);
      drive(1'b1, 10'h040, 1'b1, 1'b0, 4'hF, AW'(10'h100 + k), '0, fw, !fw);
    end
    idle();

    // Alternating fetch / load reads, back-to-back, one response per cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) drive(1'b1, AW'(10'h200 + k), 1'b0, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0);
      else            drive(1'b0, '0, 1'b1, 1'b0, 4'hF, AW'(10'h300 + k), '0, 1'b0, 1'b1);
    end
    idle();

    // Reset with a fetch read outstanding discards the response.
    if_req = 1'b1; if_addr = 10'h0AB; ls_req = 1'b0;
    #1;
    chk("rst_if_gnt", DW'(if_gnt), DW'(1'b1));
    reset_b = 1'b0;
    if_req = 1'b0;
    q.delete();
    #1;
    chk("rst_busy_async", DW'(busy), DW'(1'b0));
    @(posedge clk);
    #1;
    chk("rst_if_rvalid", DW'(if_rvalid), DW'(1'b0));
    chk("rst_busy", DW'(busy), DW'(1'b0));
    @(posedge clk);
    #1;
    reset_b = 1'b1;
    // First edge after release arbitrates normally.
    drive(1'b0, '0, 1'b1, 1'b0, 4'hF, 10'h030, '0, 1'b0, 1'b1);
    idle();
    idle();

    chk("scoreboard_empty", DW'(q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 10, word address width; DATA_WIDTH, default 32, data width; STARVE_LIMIT, default 4, consecutive lost cycles before fetch priority boost (range 1-15).
REQ-002 SHALL have the following ports:
- clk  input  1  clock; all state on rising edge
- reset_b  input  1  reset, asynchronous, active-low
- if_req  input  1  fetch read request
- if_addr  input  ADDR_WIDTH  fetch word address
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  fetch read data valid
- if_rdata  output  DATA_WIDTH  fetch read data
- ls_req  input  1  load/store request
- ls_we  input  1  1 = store, 0 = load
- ls_be  input  4  store byte enables
- ls_addr  input  ADDR_WIDTH  load/store word address
- ls_wdata  input  DATA_WIDTH  store data
- ls_gnt  output  1  load/store request accepted this cycle
- ls_rvalid  output  1  load data valid
- ls_rdata  output  DATA_WIDTH  load data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write
- mem_be  output  4  memory byte enables
- mem_addr  output  ADDR_WIDTH  memory word address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid 1 cycle after a read strobe
- busy  output  1  read response outstanding

Function
REQ-003 SHALL share one single-port synchronous memory (1-cycle read latency) between fetch (if_*) and load/store (ls_*) requesters.
REQ-004 Grant SHALL be combinational: at most one of if_gnt/ls_gnt per cycle, and only to a requester whose req is high.
REQ-005 Default priority SHALL be ls over if.
REQ-006 starve_cnt (4-bit) SHALL increment each cycle if_req=1 and if_gnt=0, saturate at STARVE_LIMIT, and clear on if_gnt or if_req=0.
REQ-007 When starve_cnt==STARVE_LIMIT and if_req=1, if SHALL win over ls that cycle.
REQ-008 In a granted cycle: mem_en=1; mem_addr, mem_we, mem_be, mem_wdata SHALL be taken from the winner; for if, mem_we=0 and mem_be=4'hF.
REQ-009 With no grant: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-010 Requesters hold req and payload stable until gnt; the arbiter SHALL accept a new grant every cycle, back-to-back.
REQ-011 A 2-bit resp_owner register SHALL record the read owner on each grant (NONE, IF, LS); a store records NONE.
REQ-012 In the cycle after a read grant, the owner's rvalid SHALL be 1 for exactly one cycle; a store SHALL produce no rvalid.
REQ-013 if_rdata and ls_rdata SHALL equal mem_rdata combinationally; they are meaningful only when the matching rvalid is 1.
REQ-014 busy SHALL equal (resp_owner != NONE).
REQ-015 A response and a new grant in the same cycle SHALL both be honoured, giving one response per cycle at full throughput.
REQ-016 if_gnt, ls_gnt and all mem_* outputs SHALL be combinational functions of the inputs and state, with no combinational path from mem_rdata.

Reset
REQ-017 While reset_b=0: resp_owner=NONE, starve_cnt=0, if_rvalid=0, ls_rvalid=0, busy=0.
REQ-018 Reset asserted with a read outstanding SHALL discard it; no rvalid after reset release until a new grant.
REQ-019 In the first edge after reset_b rises, the arbiter SHALL arbitrate normally.

Verification
REQ-020 if_req=1, addr=0x004, ls_req=0 -> same-cycle if_gnt=1, mem_en=1, mem_addr=0x004, mem_we=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-021 if_req=1 and ls_req=1 (load, addr=0x010) together -> ls_gnt=1, if_gnt=0; next cycle ls_rvalid=1, if_rvalid=0.
REQ-022 ls store (we=1, be=4'b0011, wdata=0xDEADBEEF, addr=0x020) -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; no ls_rvalid follows.
REQ-023 ls_req held high for 10 cycles with if_req high, STARVE_LIMIT=4 -> ls wins cycles 0-3, if_gnt=1 in cycle 4, ls wins cycles 5-8, if_gnt=1 in cycle 9.
REQ-024 Alternating if/ls reads every cycle -> one rvalid per cycle, each to the correct owner in order; busy stays 1.
REQ-025 if read granted, then reset_b=0 before the next edge -> if_rvalid=0 during and after reset; busy=0.
